// File: rtl/mb8_word_master_if.sv
// mb8_io: 8-bit byte-memory bus. The master drives the write enable, the byte
// address and the write byte. The slave returns the read byte one cycle after
// the address is presented.
interface mb8_io #(
   parameter int ASZ = 17
) ();
   logic           we;
   logic [ASZ-1:0] ai;
   logic [7:0]     vi;
   logic [7:0]     vo;

   modport master (output we, output ai, output vi, input vo);
   modport slave  (input we, input ai, input vi, output vo);
endinterface

// File: rtl/mb8_word_master.sv
// mb8_word_master: turns one 32-bit word access into four sequential byte
// accesses on the mb8_io bus.
// - Bytes are little-endian: byte 0 sits at the lowest address.
// - Reads allow for the one-cycle read latency of the byte memory.
// - Byte addresses wrap modulo 2^ASZ.
module mb8_word_master #(
   parameter int ASZ = 17
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req,
   input  logic           we,
   input  logic [ASZ-1:0] addr,
   input  logic [31:0]    wdata,
   output logic [31:0]    rdata,
   output logic           busy,
   output logic           done,
   mb8_io.master          b8_if
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WR   = 2'd2;

   logic [1:0]     state;
   logic [2:0]     cnt;
   logic [ASZ-1:0] addr_q;
   logic [31:0]    wdata_q;
   logic           bus_we;
   logic [1:0]     offs;

   // Sequencer: accepts a request in IDLE, then steps cnt through the byte
   // slots. rdata, busy, done and the bus write enable are all registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bus_we  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  if (we) begin
                     state  <= WR;
                     bus_we <= 1'b1;
                  end else begin
                     state  <= RD;
                  end
               end
            end
            RD: begin
               // The memory returns the byte addressed in slot cnt-1, so
               // slot cnt captures that byte into lane cnt-1.
               case (cnt)
                  3'd1:    rdata[7:0]   <= b8_if.vo;
                  3'd2:    rdata[15:8]  <= b8_if.vo;
                  3'd3:    rdata[23:16] <= b8_if.vo;
                  3'd4:    rdata[31:24] <= b8_if.vo;
                  default: ;
               endcase
               if (cnt == 3'd4) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            WR: begin
               if (cnt == 3'd3) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  bus_we <= 1'b0;
                  done   <= 1'b1;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               bus_we <= 1'b0;
            end
         endcase
      end
   end

   // Byte offset for the address and write-lane mux.
   // - cnt is left at its final value in IDLE, and the offset saturates at 3.
   // - So the last address stays on the bus between accesses without an
   //   extra holding register.
   // - This also covers the RD slot cnt=4, which keeps addr+3 on the bus.
   always_comb begin
      offs = (cnt > 3'd3) ? 2'd3 : cnt[1:0];
   end

   // Bus address and write byte, muxed from the latched request.
   always_comb begin
      b8_if.ai = addr_q + {{(ASZ-2){1'b0}}, offs};
      case (offs)
         2'd0:    b8_if.vi = wdata_q[7:0];
         2'd1:    b8_if.vi = wdata_q[15:8];
         2'd2:    b8_if.vi = wdata_q[23:16];
         default: b8_if.vi = wdata_q[31:24];
      endcase
   end

   assign b8_if.we = bus_we;

   // Structural invariants of the sequencer.
   a_done_idle : assert property (@(posedge clk) disable iff (rst) done |-> !busy);
   a_we_busy   : assert property (@(posedge clk) disable iff (rst) b8_if.we |-> busy);

endmodule

// File: tb/tb_mb8_word_master.sv
// tb_mb8_word_master: directed test of mb8_word_master.
// - A behavioural byte memory with one-cycle read latency is attached to the
//   bus.
// - Inputs are driven 1 ns after the rising edge.
// - Outputs are sampled at that same point.
module tb_mb8_word_master;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [16:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   bit [7:0] mem [0:131071];

   mb8_io #(.ASZ(17)) b8 ();

   mb8_word_master #(.ASZ(17)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .busy  (busy),
      .done  (done),
      .b8_if (b8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte memory model: synchronous write, registered read data.
   always @(posedge clk) begin
      if (b8.we === 1'b1) mem[b8.ai] <= b8.vi;
      b8.vo <= mem[b8.ai];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issues one word access from the current cycle.
   // - Returns the cycle count from the req cycle to the done cycle.
   // - Leaves the bench in the done cycle, so a following call is issued
   //   back-to-back.
   task automatic word_op(input string tag, input logic w, input logic [16:0] a,
                          input logic [31:0] d, output int lat);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
      lat = 1;
      check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
      while (done !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int lat;
      int ndone;
      logic [31:0] rd_at_done;

      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_we",    {31'd0, b8.we}, 32'd0);
      check("rst_ai",    {15'd0, b8.ai}, 32'd0);
      check("rst_vi",    {24'd0, b8.vi}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Aligned write, then read back.
      word_op("wr100", 1'b1, 17'h00100, 32'h12345678, lat);
      check("wr100_lat", lat, 5);
      check("wr100_rdata_kept", rdata, 32'd0);
      check("wr100_ai_hold", {15'd0, b8.ai}, 32'h00103);
      word_op("rd100", 1'b0, 17'h00100, 32'h0, lat);
      check("rd100_lat", lat, 6);
      check("rd100_rdata", rdata, 32'h12345678);
      check("mem100", {24'd0, mem[17'h00100]}, 32'h78);
      check("mem101", {24'd0, mem[17'h00101]}, 32'h56);
      check("mem102", {24'd0, mem[17'h00102]}, 32'h34);
      check("mem103", {24'd0, mem[17'h00103]}, 32'h12);

      // Read of zeroed memory, so the next read visibly changes rdata.
      word_op("rd200", 1'b0, 17'h00200, 32'h0, lat);
      check("rd200_rdata", rdata, 32'd0);

      // A req pulse during a read is ignored.
      req = 1'b1; we = 1'b0; addr = 17'h00100;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      req = 1'b1; addr = 17'h00200;
      @(posedge clk); #1;
      req = 1'b0;
      ndone = 0;
      rd_at_done = '0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) begin
            ndone++;
            rd_at_done = rdata;
         end
         @(posedge clk); #1;
      end
      check("midreq_ndone", ndone, 1);
      check("midreq_rdata", rd_at_done, 32'h12345678);

      // A write immediately followed by a read issued in its done cycle.
      word_op("wr180", 1'b1, 17'h00180, 32'h55AA0FF0, lat);
      check("wr180_lat", lat, 5);
      check("wr180_rdata_kept", rdata, 32'h12345678);
      word_op("b2b", 1'b0, 17'h00180, 32'h0, lat);
      check("b2b_lat", lat, 6);
      check("b2b_rdata", rdata, 32'h55AA0FF0);

      // Unaligned word.
      word_op("wr103", 1'b1, 17'h00103, 32'hA1B2C3D4, lat);
      word_op("rd103", 1'b0, 17'h00103, 32'h0, lat);
      check("rd103_rdata", rdata, 32'hA1B2C3D4);
      check("mem102_unch", {24'd0, mem[17'h00102]}, 32'h34);
      check("mem103_new", {24'd0, mem[17'h00103]}, 32'hD4);

      // Address wrap at the top of the byte space.
      word_op("wrwrap", 1'b1, 17'h1FFFF, 32'hCAFEF00D, lat);
      check("wrap_1ffff", {24'd0, mem[17'h1FFFF]}, 32'h0D);
      check("wrap_00000", {24'd0, mem[17'h00000]}, 32'hF0);
      check("wrap_00001", {24'd0, mem[17'h00001]}, 32'hFE);
      check("wrap_00002", {24'd0, mem[17'h00002]}, 32'hCA);
      word_op("rdwrap", 1'b0, 17'h1FFFF, 32'h0, lat);
      check("rdwrap_rdata", rdata, 32'hCAFEF00D);

      // Reset during the third WR cycle aborts the write.
      req = 1'b1; we = 1'b1; addr = 17'h00300; wdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_we_before", {31'd0, b8.we}, 32'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_we",   {31'd0, b8.we}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      check("abort_ndone", ndone, 0);
      check("abort_m300", {24'd0, mem[17'h00300]}, 32'hFF);
      check("abort_m301", {24'd0, mem[17'h00301]}, 32'hFF);
      check("abort_m302", {24'd0, mem[17'h00302]}, 32'h00);
      check("abort_m303", {24'd0, mem[17'h00303]}, 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
